bit_scan_encoder: RTL and testbench
===================================

// Module: bit_scan_encoder
// PURPOSE
//  Sequential encoder, the inverse of the team's one-hot decoders. Captures an
//  N-bit request vector and emits the binary index of every set bit, lowest
//  first, one index per valid/ready handshake. Sits between a bank of request
//  flags and a consumer that needs them as select codes.
// PARAMETERS
//  N  8          width of request vector (N >= 2)
//  M  $clog2(N)  width of emitted index Y
// PORTS
//  CLK    in   1    clock, all state changes on rising edge
//  RESET  in   1    synchronous, active-high reset
//  REQ    in   N    request vector, sampled only when LOAD accepted
//  LOAD   in   1    capture REQ and start a burst (accepted only when BUSY=0)
//  BUSY   out  1    1 while a burst is in progress (state SCAN)
//  Y      out  M    index of lowest pending bit; meaningful only when VALID=1
//  VALID  out  1    Y holds an index not yet consumed
//  READY  in   1    consumer accepts Y on a cycle where VALID&&READY
//  DONE   out  1    single-cycle pulse: burst finished (or empty load)
//  COUNT  out  M+1  indices emitted in the current/last burst
// BEHAVIOUR
//  - Reset: state IDLE, PEND=0, BUSY=0, VALID=0, DONE=0, COUNT=0, Y=0.
//  - Internal PEND[N-1:0] register holds unserved bits.
//  - Y = index of lowest set bit of PEND (combinational from the register);
//    Y=0 when PEND=0.
//  - VALID = (state==SCAN); BUSY = VALID.
//  - FSM states: IDLE, SCAN.
//    IDLE: LOAD=1, REQ!=0 -> PEND<=REQ, COUNT<=0, go SCAN (VALID at t+1).
//          LOAD=1, REQ==0 -> stay IDLE, COUNT<=0, DONE=1 at t+1.
//    SCAN: VALID&&READY -> clear served bit in PEND, COUNT<=COUNT+1;
//          if served bit was the last one -> go IDLE, DONE=1 next cycle.
//          READY=0 -> PEND, Y, COUNT held stable (no change while stalled).
//  - Throughput: one index per cycle while READY=1.
//  - Latency: LOAD at edge t -> first index on Y after edge t.
//    Last handshake at edge t -> DONE, BUSY=0 after edge t.
//  - DONE high for exactly one cycle; COUNT holds its value until next LOAD.
//  - LOAD while BUSY=1 ignored; REQ changes during SCAN have no effect.
//  - LOAD in the cycle DONE is high is accepted (state already IDLE).
//  - COUNT max value N (hence M+1 bits); never wraps.
//  - RESET mid-burst: abort immediately, all outputs to reset values, no DONE.
// TESTING
//  1. N=8, REQ=8'b1010_0100, LOAD, READY=1 -> Y=2,5,7 on 3 consecutive
//     VALID cycles, then DONE pulse, COUNT=3, BUSY=0.
//  2. Same REQ, READY=0 for 3 cycles after first VALID -> Y held at 2,
//     VALID=1, COUNT=0; then READY=1 -> 5,7, COUNT=3.
//  3. REQ=8'h00, LOAD -> DONE=1 next cycle only, VALID never set, COUNT=0.
//  4. REQ=8'hFF, READY=1 -> Y=0..7 consecutive, COUNT=8, DONE once.
//  5. LOAD with REQ=8'h01 during burst of 8'h80 ignored (only Y=7 emitted);
//     RESET during SCAN of 8'hF0 after one handshake -> VALID=0, COUNT=0,
//     no DONE.
//  6. N=5 instance, REQ=5'b10001 -> Y=0 then Y=4, COUNT=2; back-to-back LOAD
//     in DONE cycle starts new burst next cycle.

Source files
------------

// File: rtl/bit_scan_encoder.sv
// ----------------------------------------------------------------------------
// bit_scan_encoder
//
// Sequential priority encoder. A request vector is captured on an accepted
// load and then every set bit is emitted as a binary index, lowest first,
// one index per valid/ready handshake. A single-cycle done pulse marks the
// end of each burst (including a load of an all-zero vector), and count
// reports how many indices the current or most recent burst has emitted.
//
// Ports
//   clk    in   1     clock, all state changes on the rising edge
//   reset  in   1     synchronous, active-high reset
//   req    in   N     request vector, sampled only when a load is accepted
//   load   in   1     capture req and start a burst (only while idle)
//   busy   out  1     high while a burst is in progress
//   y      out  M     index of the lowest pending bit (0 when nothing pending)
//   valid  out  1     y holds an index not yet consumed
//   ready  in   1     consumer takes y on a cycle where valid && ready
//   done   out  1     one-cycle pulse after the last handshake / empty load
//   count  out  M+1   indices emitted in the current/last burst
// ----------------------------------------------------------------------------
module bit_scan_encoder #(
    parameter int N = 8,
    parameter int M = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         load,
    output logic         busy,
    output logic [M-1:0] y,
    output logic         valid,
    input  logic         ready,
    output logic         done,
    output logic [M:0]   count
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [M:0]     count_q, count_d;
    logic           done_q, done_d;

    logic [N-1:0]   lowest_onehot;
    logic [M-1:0]   lowest_index;

    // State register: every flop of the block, cleared together on reset so
    // an aborted burst leaves no pending bits and raises no done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Lowest pending bit, both as a one-hot mask (two's-complement trick:
    // x & -x isolates the least significant one) and as a binary index.
    // The index loop runs high to low so the lowest set bit wins; with no
    // bit pending the index stays 0.
    always_comb begin
        lowest_onehot = pend_q & (~pend_q + {{(N-1){1'b0}}, 1'b1});
        lowest_index  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                lowest_index = M'(i);
            end
        end
    end

    // Next-state logic. Loads are only looked at in IDLE, so a load during a
    // burst is dropped and req is never sampled mid-burst. A handshake on the
    // last pending bit returns to IDLE and schedules done for the next cycle,
    // which is also why a load in the done cycle is accepted straight away.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        count_d = count_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    count_d = '0;
                    if (req != '0) begin
                        pend_d  = req;
                        state_d = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (ready) begin
                    pend_d  = pend_q & ~lowest_onehot;
                    count_d = count_q + {{M{1'b0}}, 1'b1};
                    if ((pend_q & ~lowest_onehot) == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are all decoded from registered state, so nothing on the
    // consumer side ever sees a combinational path from ready or load.
    always_comb begin
        valid = (state_q == SCAN);
        busy  = (state_q == SCAN);
        y     = lowest_index;
        done  = done_q;
        count = count_q;
    end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// ----------------------------------------------------------------------------
// tb_bit_scan_encoder
//
// Scoreboard bench for two bit_scan_encoder instances (N=8 and N=5). The
// stimulus side keeps a burst-level model: on every accepted load it lists
// the set bits of req in ascending order and queues one expected index per
// bit followed by one expected done entry. Independent monitors on the
// falling edge pop and compare whenever a DUT shows a handshake or done.
// ----------------------------------------------------------------------------
module tb_bit_scan_encoder;

    typedef struct {
        bit is_done;
        int value;
        int cnt;
    } exp_t;

    logic       clk;
    logic       reset;

    logic [7:0] req8;
    logic       load8, ready8, busy8, valid8, done8;
    logic [2:0] y8;
    logic [3:0] count8;

    logic [4:0] req5;
    logic       load5, ready5, busy5, valid5, done5;
    logic [2:0] y5;
    logic [3:0] count5;

    exp_t q8[$];
    exp_t q5[$];
    int   rem8, rem5;
    bit   exp_valid8, exp_valid5;

    int   checks;
    int   errors;

    bit_scan_encoder #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .req(req8), .load(load8), .busy(busy8),
        .y(y8), .valid(valid8), .ready(ready8), .done(done8), .count(count8)
    );

    bit_scan_encoder #(.N(5)) dut5 (
        .clk(clk), .reset(reset), .req(req5), .load(load5), .busy(busy5),
        .y(y5), .valid(valid5), .ready(ready5), .done(done5), .count(count5)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic flagUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=present expected=absent at %0t", name, $time);
    endtask

    // Reference model: a burst is the ascending list of set bit positions,
    // each expected with the number already served, then done with the total
    task automatic modelLoad8(input logic [7:0] r);
        int k = 0;
        for (int i = 0; i < 8; i++) begin
            if (((r >> i) & 8'd1) != 0) begin
                q8.push_back('{1'b0, i, k});
                k++;
            end
        end
        q8.push_back('{1'b1, k, k});
        rem8 = k;
    endtask

    task automatic modelLoad5(input logic [4:0] r);
        int k = 0;
        for (int i = 0; i < 5; i++) begin
            if (((r >> i) & 5'd1) != 0) begin
                q5.push_back('{1'b0, i, k});
                k++;
            end
        end
        q5.push_back('{1'b1, k, k});
        rem5 = k;
    endtask

    // Advance both models across the coming edge, then let the edge happen
    task automatic applyStimulus();
        if (rem8 > 0) begin
            if (ready8) rem8--;
        end else if (load8) begin
            modelLoad8(req8);
        end
        if (rem5 > 0) begin
            if (ready5) rem5--;
        end else if (load5) begin
            modelLoad5(req5);
        end
        @(posedge clk);
        #1;
        exp_valid8 = (rem8 > 0);
        exp_valid5 = (rem5 > 0);
    endtask

    task automatic applyReset();
        reset  = 1'b1;
        load8  = 1'b0;
        ready8 = 1'b0;
        load5  = 1'b0;
        ready5 = 1'b0;
        q8.delete();
        q5.delete();
        rem8 = 0;
        rem5 = 0;
        @(posedge clk);
        #1;
        exp_valid8 = 1'b0;
        exp_valid5 = 1'b0;
        checkOutput("reset_valid8", valid8, 0);
        checkOutput("reset_busy8", busy8, 0);
        checkOutput("reset_done8", done8, 0);
        checkOutput("reset_count8", count8, 0);
        checkOutput("reset_y8", y8, 0);
        checkOutput("reset_valid5", valid5, 0);
        checkOutput("reset_count5", count5, 0);
        reset = 1'b0;
    endtask

    // Monitor for the N=8 instance
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("valid8", valid8, exp_valid8);
            checkOutput("busy8", busy8, exp_valid8);
            if (valid8) begin
                if (q8.size() == 0 || q8[0].is_done) begin
                    flagUnexpected("index8");
                end else begin
                    checkOutput("y8", y8, q8[0].value);
                    checkOutput("count8_run", count8, q8[0].cnt);
                    if (ready8) void'(q8.pop_front());
                end
            end else begin
                checkOutput("y8_idle", y8, 0);
            end
            if (done8) begin
                if (q8.size() == 0 || !q8[0].is_done) begin
                    flagUnexpected("done8");
                end else begin
                    checkOutput("done_count8", count8, q8[0].value);
                    void'(q8.pop_front());
                end
            end
        end
    end

    // Monitor for the N=5 instance
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("valid5", valid5, exp_valid5);
            checkOutput("busy5", busy5, exp_valid5);
            if (valid5) begin
                if (q5.size() == 0 || q5[0].is_done) begin
                    flagUnexpected("index5");
                end else begin
                    checkOutput("y5", y5, q5[0].value);
                    checkOutput("count5_run", count5, q5[0].cnt);
                    if (ready5) void'(q5.pop_front());
                end
            end else begin
                checkOutput("y5_idle", y5, 0);
            end
            if (done5) begin
                if (q5.size() == 0 || !q5[0].is_done) begin
                    flagUnexpected("done5");
                end else begin
                    checkOutput("done_count5", count5, q5[0].value);
                    void'(q5.pop_front());
                end
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rem8       = 0;
        rem5       = 0;
        exp_valid8 = 1'b0;
        exp_valid5 = 1'b0;
        req8       = '0;
        req5       = '0;
        load8      = 1'b0;
        load5      = 1'b0;
        ready8     = 1'b0;
        ready5     = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        applyReset();

        // Sparse vector, consumer always ready
        req8 = 8'b1010_0100; load8 = 1'b1; ready8 = 1'b1;
        applyStimulus();
        load8 = 1'b0;
        repeat (5) applyStimulus();
        checkOutput("count8_hold", count8, 3);
        checkOutput("busy8_after", busy8, 0);

        // Same vector with a three-cycle stall on the first index
        load8 = 1'b1; ready8 = 1'b0;
        applyStimulus();
        load8 = 1'b0;
        repeat (3) applyStimulus();
        ready8 = 1'b1;
        repeat (4) applyStimulus();
        checkOutput("count8_stall", count8, 3);

        // Empty load: done only, no valid
        req8 = 8'h00; load8 = 1'b1;
        applyStimulus();
        load8 = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("count8_empty", count8, 0);

        // Full vector: all eight indices back to back
        req8 = 8'hFF; load8 = 1'b1;
        applyStimulus();
        load8 = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("count8_full", count8, 8);

        // Load during a burst is ignored
        req8 = 8'h80; load8 = 1'b1; ready8 = 1'b0;
        applyStimulus();
        req8 = 8'h01; load8 = 1'b1;
        applyStimulus();
        load8 = 1'b0; ready8 = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("count8_ignore", count8, 1);

        // Reset after one handshake of a four-index burst
        req8 = 8'hF0; load8 = 1'b1; ready8 = 1'b1;
        applyStimulus();
        load8 = 1'b0;
        applyStimulus();
        applyReset();
        repeat (3) applyStimulus();

        // N=5: two-index burst, then a load in the done cycle
        req5 = 5'b10001; load5 = 1'b1; ready5 = 1'b1;
        applyStimulus();
        load5 = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("done5_cycle", done5, 1);
        req5 = 5'b01010; load5 = 1'b1;
        applyStimulus();
        load5 = 1'b0;
        checkOutput("b2b_valid5", valid5, 1);
        repeat (3) applyStimulus();
        checkOutput("count5_b2b", count5, 2);

        // Randomized traffic on both instances
        for (int c = 0; c < 400; c++) begin
            load8  = ($urandom_range(0, 3) == 0);
            req8   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ready8 = ($urandom_range(0, 3) != 0);
            load5  = ($urandom_range(0, 3) == 0);
            req5   = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
            ready5 = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        // Drain: bursts are at most eight indices plus done
        load8 = 1'b0; ready8 = 1'b1;
        load5 = 1'b0; ready5 = 1'b1;
        repeat (12) applyStimulus();
        checkOutput("drain8", q8.size(), 0);
        checkOutput("drain5", q5.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
